// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks a command ROM of {op, addr, data} words and turns it into
// SCCB register writes, millisecond delays and an END marker, with bounded NACK retry.
module sccb_init_sequencer #(
   parameter int INPUT_CLK_FREQ = 25000000,
   parameter int ROM_ADDR_W     = 8,
   parameter int REG_ADDR_W     = 8,
   parameter int REG_DATA_W     = 8,
   parameter int MAX_RETRY      = 3,
   localparam int ROM_W         = 2 + REG_ADDR_W + REG_DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic [ROM_ADDR_W-1:0] rom_select,
   input  logic [ROM_W-1:0]      rom_out,
   input  logic                  sccb_ready,
   output logic                  sccb_start_sign,
   output logic [REG_ADDR_W-1:0] sccb_sub_address,
   output logic [REG_DATA_W-1:0] sccb_set_data,
   input  logic                  sccb_done,
   input  logic                  sccb_nack,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ROM_ADDR_W-1:0] error_index,
   output logic [ROM_ADDR_W-1:0] write_count
);
   localparam int MS_CYCLES = INPUT_CLK_FREQ / 1000;
   localparam int CYC_W     = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CYC_W-1:0]   CYC_RELOAD = CYC_W'(MS_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_DELAY = 2'b01;
   localparam logic [1:0] OP_END   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_ISSUE, ST_WAIT_DONE, ST_DELAY, ST_DONE, ST_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [ROM_ADDR_W-1:0]   rom_select_q, rom_select_d;
   logic [REG_ADDR_W-1:0]   sub_address_q, sub_address_d;
   logic [REG_DATA_W-1:0]   set_data_q, set_data_d;
   logic                    start_sign_q, start_sign_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [ROM_ADDR_W-1:0]   error_index_q, error_index_d;
   logic [ROM_ADDR_W-1:0]   write_count_q, write_count_d;
   logic [RETRY_W-1:0]      retry_q, retry_d;
   logic [REG_DATA_W-1:0]   ms_q, ms_d;
   logic [CYC_W-1:0]        cyc_q, cyc_d;
   logic                    advance;
   logic                    begin_run;

   logic [1:0]              rom_op;
   logic [REG_ADDR_W-1:0]   rom_addr;
   logic [REG_DATA_W-1:0]   rom_data;

   assign rom_op   = rom_out[ROM_W-1 -: 2];
   assign rom_addr = rom_out[REG_DATA_W +: REG_ADDR_W];
   assign rom_data = rom_out[REG_DATA_W-1:0];

   always_comb begin
      state_d       = state_q;
      rom_select_d  = rom_select_q;
      sub_address_d = sub_address_q;
      set_data_d    = set_data_q;
      start_sign_d  = 1'b0;
      done_d        = done_q;
      error_d       = error_q;
      error_index_d = error_index_q;
      write_count_d = write_count_q;
      retry_d       = retry_q;
      ms_d          = ms_q;
      cyc_d         = cyc_q;
      advance       = 1'b0;
      begin_run     = 1'b0;

      case (state_q)
         ST_IDLE, ST_ERROR: begin
            if (start) begin_run = 1'b1;
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            case (rom_op)
               OP_WRITE: state_d = ST_ISSUE;
               OP_DELAY: begin
                  if (rom_data == '0) begin
                     advance = 1'b1;
                  end else begin
                     state_d = ST_DELAY;
                     ms_d    = rom_data;
                     cyc_d   = CYC_RELOAD;
                  end
               end
               OP_END: begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
               default: advance = 1'b1;
            endcase
         end
         ST_ISSUE: begin
            if (sccb_ready) begin
               sub_address_d = rom_addr;
               set_data_d    = rom_data;
               start_sign_d  = 1'b1;
               state_d       = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (sccb_done) begin
               if (!sccb_nack) begin
                  write_count_d = write_count_q + 1'b1;
                  retry_d       = '0;
                  advance       = 1'b1;
               end else if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  state_d       = ST_ERROR;
                  error_d       = 1'b1;
                  error_index_d = rom_select_q;
               end
            end
         end
         ST_DELAY: begin
            // The last millisecond ends when ms is still 1, giving exactly data*MS_CYCLES cycles.
            if (cyc_q == '0) begin
               cyc_d = CYC_RELOAD;
               ms_d  = ms_q - 1'b1;
               if (ms_q == REG_DATA_W'(1)) advance = 1'b1;
            end else begin
               cyc_d = cyc_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (begin_run) begin
         state_d       = ST_FETCH;
         rom_select_d  = '0;
         write_count_d = '0;
         done_d        = 1'b0;
         error_d       = 1'b0;
         retry_d       = '0;
      end

      if (advance) begin
         if (rom_select_q == '1) begin
            state_d       = ST_ERROR;
            error_d       = 1'b1;
            error_index_d = rom_select_q;
         end else begin
            rom_select_d = rom_select_q + 1'b1;
            state_d      = ST_FETCH;
         end
      end

      // Abort wins over everything but leaves the completion flags as they were.
      if (abort) begin
         state_d       = ST_IDLE;
         start_sign_d  = 1'b0;
         done_d        = done_q;
         error_d       = error_q;
         error_index_d = error_index_q;
      end

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERROR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         rom_select_q  <= '0;
         sub_address_q <= '0;
         set_data_q    <= '0;
         start_sign_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         error_index_q <= '0;
         write_count_q <= '0;
         retry_q       <= '0;
         ms_q          <= '0;
         cyc_q         <= '0;
      end else begin
         state_q       <= state_d;
         rom_select_q  <= rom_select_d;
         sub_address_q <= sub_address_d;
         set_data_q    <= set_data_d;
         start_sign_q  <= start_sign_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         error_index_q <= error_index_d;
         write_count_q <= write_count_d;
         retry_q       <= retry_d;
         ms_q          <= ms_d;
         cyc_q         <= cyc_d;
      end
   end

   assign rom_select       = rom_select_q;
   assign sccb_start_sign  = start_sign_q;
   assign sccb_sub_address = sub_address_q;
   assign sccb_set_data    = set_data_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign error_index      = error_index_q;
   assign write_count      = write_count_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench for sccb_init_sequencer: ROM and SCCB responder models, expected
// write/result queues checked by a monitor that samples on the falling edge.
`timescale 1ns/1ps
module tb_sccb_init_sequencer;
   localparam int AW = 4;
   localparam int RW = 18;

   logic          clk = 1'b0;
   logic          reset, start, abort;
   logic [AW-1:0] rom_select;
   logic [RW-1:0] rom_out;
   logic          sccb_ready, sccb_start_sign;
   logic [7:0]    sccb_sub_address, sccb_set_data;
   logic          sccb_done, sccb_nack;
   logic          busy, done, error;
   logic [AW-1:0] error_index, write_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sccb_init_sequencer #(
      .INPUT_CLK_FREQ(4000), .ROM_ADDR_W(AW), .REG_ADDR_W(8), .REG_DATA_W(8), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rom_select(rom_select), .rom_out(rom_out),
      .sccb_ready(sccb_ready), .sccb_start_sign(sccb_start_sign),
      .sccb_sub_address(sccb_sub_address), .sccb_set_data(sccb_set_data),
      .sccb_done(sccb_done), .sccb_nack(sccb_nack),
      .busy(busy), .done(done), .error(error),
      .error_index(error_index), .write_count(write_count)
   );

   // Synchronous ROM: one cycle read latency.
   logic [RW-1:0] rom [16];
   always @(posedge clk) rom_out <= rom[rom_select];

   localparam logic [RW-1:0] W_END = {2'b10, 16'h0000};
   localparam logic [RW-1:0] W_NOP = {2'b11, 16'h0000};

   function automatic logic [RW-1:0] wr(input logic [7:0] a, input logic [7:0] d);
      return {2'b00, a, d};
   endfunction

   function automatic logic [RW-1:0] dl(input logic [7:0] d);
      return {2'b01, 8'h00, d};
   endfunction

   typedef struct {
      logic       done;
      logic       error;
      logic [3:0] wc;
      logic [3:0] idx;
      bit         chk_busy;
      int         busy_cycles;
   } res_t;

   function automatic res_t mk_res(input logic d, input logic e, input int wc, input int idx,
                                   input bit cb, input int bc);
      res_t r;
      r.done = d; r.error = e; r.wc = 4'(wc); r.idx = 4'(idx);
      r.chk_busy = cb; r.busy_cycles = bc;
      return r;
   endfunction

   logic [15:0] exp_start_q[$];
   res_t        exp_res_q[$];
   bit          nack_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // SCCB master model: done pulse 5 cycles after each start pulse, nack from the plan queue.
   initial begin
      int cnt;
      cnt = 0;
      sccb_ready = 1'b1; sccb_done = 1'b0; sccb_nack = 1'b0;
      forever begin
         @(negedge clk);
         sccb_done = 1'b0; sccb_nack = 1'b0;
         if (!reset) begin
            cnt = 0; sccb_ready = 1'b1;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  sccb_done = 1'b1;
                  if (nack_q.size() > 0) sccb_nack = nack_q.pop_front();
                  sccb_ready = 1'b1;
               end
            end
            if (sccb_start_sign) begin
               cnt = 5; sccb_ready = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expected writes on each start pulse, expected results on done/error rise.
   initial begin
      int          busy_cnt;
      logic        done_p, err_p;
      logic [15:0] e;
      res_t        r;
      busy_cnt = 0; done_p = 1'b0; err_p = 1'b0;
      forever begin
         @(negedge clk);
         if (start && !busy) busy_cnt = 0;
         else if (busy) busy_cnt++;
         if (sccb_start_sign) begin
            if (exp_start_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL start_pulse actual=%h/%h required=none", sccb_sub_address, sccb_set_data);
            end else begin
               e = exp_start_q.pop_front();
               chk("write_addr", sccb_sub_address, e[15:8]);
               chk("write_data", sccb_set_data, e[7:0]);
            end
         end
         if ((done && !done_p) || (error && !err_p)) begin
            if (exp_res_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL result actual=done%0b/error%0b required=none", done, error);
            end else begin
               r = exp_res_q.pop_front();
               chk("res_done", done, r.done);
               chk("res_error", error, r.error);
               chk("res_write_count", write_count, r.wc);
               if (r.error) chk("res_error_index", error_index, r.idx);
               if (r.chk_busy) chk("res_busy_cycles", busy_cnt, r.busy_cycles);
            end
         end
         done_p = done; err_p = error;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = W_END;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_results(input string name, input int budget);
      int n;
      n = 0;
      while (exp_res_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      if (exp_res_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=pending%0d required=0", name, exp_res_q.size());
         exp_res_q.delete();
      end
      chk({name, "_writes_missing"}, exp_start_q.size(), 0);
      exp_start_q.delete();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_rom_select"}, rom_select, 0);
      chk({name, "_start_sign"}, sccb_start_sign, 0);
      chk({name, "_sub_address"}, sccb_sub_address, 0);
      chk({name, "_set_data"}, sccb_set_data, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_error"}, error, 0);
      chk({name, "_error_index"}, error_index, 0);
      chk({name, "_write_count"}, write_count, 0);
   endtask

   initial begin
      int n;
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      clear_rom();
      tick(3);
      chk_all_zero("reset");
      reset = 1'b1;
      tick(2);

      // 1: two acknowledged writes then END
      clear_rom();
      rom[0] = wr(8'h12, 8'h80); rom[1] = wr(8'h3A, 8'h04); rom[2] = W_END;
      exp_start_q.push_back(16'h1280); exp_start_q.push_back(16'h3A04);
      exp_res_q.push_back(mk_res(1'b1, 1'b0, 2, 0, 1'b0, 0));
      pulse_start();
      wait_results("t1", 200);
      tick(3);
      chk("t1_done_held", done, 1);

      // 2: DELAY 3 -> FETCH,DECODE,12 delay,FETCH,DECODE = 16 busy cycles; DELAY 0 -> 4
      clear_rom();
      rom[0] = dl(8'd3);
      exp_res_q.push_back(mk_res(1'b1, 1'b0, 0, 0, 1'b1, 16));
      pulse_start();
      wait_results("t2a", 200);
      rom[0] = dl(8'd0);
      exp_res_q.push_back(mk_res(1'b1, 1'b0, 0, 0, 1'b1, 4));
      pulse_start();
      wait_results("t2b", 200);

      // 3: two NACKs then ACK
      clear_rom();
      rom[0] = wr(8'h12, 8'h80);
      nack_q = '{1'b1, 1'b1, 1'b0};
      repeat (3) exp_start_q.push_back(16'h1280);
      exp_res_q.push_back(mk_res(1'b1, 1'b0, 1, 0, 1'b0, 0));
      pulse_start();
      wait_results("t3", 300);

      // 4: NACK forever -> error at index 0 after three attempts
      nack_q = '{1'b1, 1'b1, 1'b1};
      repeat (3) exp_start_q.push_back(16'h1280);
      exp_res_q.push_back(mk_res(1'b0, 1'b1, 0, 0, 1'b0, 0));
      pulse_start();
      wait_results("t4", 300);

      // 5: full ROM of NOP/WRITE with no END -> overrun at index 15
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) begin
            rom[i] = W_NOP;
         end else begin
            rom[i] = wr(8'(i), 8'(i * 3));
            exp_start_q.push_back({8'(i), 8'(i * 3)});
         end
      end
      exp_res_q.push_back(mk_res(1'b0, 1'b1, 8, 15, 1'b0, 0));
      pulse_start();
      wait_results("t5", 800);

      // 6a: abort in the middle of a long delay
      clear_rom();
      rom[0] = dl(8'd100);
      pulse_start();
      tick(10);
      chk("t6a_busy_before_abort", busy, 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t6a_busy_after_abort", busy, 0);
      chk("t6a_done", done, 0);
      chk("t6a_error", error, 0);
      tick(5);
      chk("t6a_still_idle", busy, 0);

      // 6b: reset during WAIT_DONE, then a clean restart from word 0
      clear_rom();
      rom[0] = wr(8'h55, 8'hAA); rom[1] = wr(8'h66, 8'hBB); rom[2] = W_END;
      exp_start_q.push_back(16'h55AA);
      pulse_start();
      n = 0;
      while (exp_start_q.size() != 0 && n < 50) begin
         tick(1);
         n++;
      end
      chk("t6b_first_write_issued", exp_start_q.size(), 0);
      exp_start_q.delete();
      tick(2);
      reset = 1'b0;
      #1;
      chk_all_zero("t6b_midreset");
      tick(2);
      reset = 1'b1;
      tick(20);
      exp_start_q.push_back(16'h55AA); exp_start_q.push_back(16'h66BB);
      exp_res_q.push_back(mk_res(1'b1, 1'b0, 2, 0, 1'b0, 0));
      pulse_start();
      wait_results("t6b_restart", 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
